linebuf_sched: RTL and testbench
================================

Name: linebuf_sched

Overview:
- Ping-pong scheduler for two 1024x11 scanline buffers used by the sprite pipeline.
- Each line, one bank is the draw bank: the sprite engine read-modify-writes pixels into it. The other bank is the display bank: video scans it out and clears it behind the beam.
- Banks swap on every line_start pulse.
- Sits between the sprite renderer, the video timing generator and two external scanline buffer instances.

Parameters:
- AW, 10, pixel address width (buffer depth 2**AW)
- DW, 11, pixel word width (palette bank + colour)
- TW, 4, number of LSBs forming the colour index; zero means transparent

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- line_start  in  1  one-cycle pulse at start of each scanline; swaps banks
- rd_en  in  1  active display pixel this cycle
- hpos  in  AW  display read address
- pix_out  out  DW  display pixel, bank-muxed
- spr_valid  in  1  sprite pixel request
- spr_ready  out  1  request accepted when valid & ready
- spr_x  in  AW  sprite pixel x
- spr_dat  in  DW  sprite pixel value
- busy  out  1  RMW in flight
- b0_radr / b1_radr  out  AW  bank read/clear address
- b0_clre / b1_clre  out  1  read-and-clear strobe
- b0_rdat / b1_rdat  in  DW  bank read data (1-cycle latency)
- b0_wadr / b1_wadr  out  AW  bank write-port address
- b0_wdat / b1_wdat  out  DW  bank write data
- b0_we / b1_we  out  1  bank write enable
- b0_rdat1 / b1_rdat1  in  DW  bank write-port readback (1-cycle latency)
- coll  out  1  collision pulse (optional feature)
- coll_x  out  AW  collision x (optional feature)

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on port reset.
- Reset values: draw_bank=0, FSM=IDLE, spr_ready=1, busy=0, all we/clre=0, all addresses/wdat=0, pix_out=0, coll=0, coll_x=0.
- Bank swap: on line_start, draw_bank toggles next cycle. Display bank is always ~draw_bank.
- Display path:
  - Display bank gets radr=hpos and clre=rd_en in the same cycle, combinational from registered bank select.
  - Draw bank gets radr=0 and clre=0.
  - pix_out = rdat of the bank that was display bank one cycle earlier, so latency is 1 cycle from hpos.
  - When rd_en was low in the previous cycle, pix_out=0.
- Sprite path FSM:
  - IDLE:
    - spr_ready=1.
    - On valid: latch x, dat, and target bank (current draw_bank).
    - Drive target wadr=x with we=0. Go to RD.
  - RD:
    - spr_ready=0, busy=1.
    - Target rdat1 holds the old pixel. Go to WR.
  - WR:
    - Write (we=1, wadr=x, wdat=dat) only if old[TW-1:0]==0 and dat[TW-1:0]!=0. First-drawn opaque pixel wins.
    - Go to IDLE.
  - Throughput: one pixel per 3 cycles.
  - spr_ready is a registered output: low in RD and WR, high in IDLE.
- Boundary cases:
  - line_start during RD/WR: the in-flight pixel completes to its latched bank (now the display bank). Its write port is used only by the FSM, so there is no conflict with the clear. The next accepted pixel goes to the new draw bank.
  - line_start and acceptance in the same cycle: pixel targets the pre-toggle draw_bank.
  - Display clear and FSM write to the same bank and same address on the same edge: the write port wins. This is permitted only in the swap-straddle case above.
  - Transparent sprite pixel (dat[TW-1:0]==0): full RMW sequence, no write.
  - spr_x wraps naturally at 2**AW.
  - Reset mid-RMW: FSM returns to IDLE, pending write dropped, we=0 on the following cycle.

Optional Feature:
- Macro: LBSCHED_COLLISION_EN
- Defined:
  - In WR, if old[TW-1:0]!=0 and dat[TW-1:0]!=0, coll pulses for 1 cycle and coll_x=x (held until next pulse).
  - Write suppression is unchanged.
- Undefined: coll and coll_x tied to 0, no comparator logic.

Decomposition:
- Shared package lbsched_pkg:
  - FSM state enum {IDLE, RD, WR}
  - Default AW/DW/TW constants
  - Transparency test function is_opaque(dat)
- One sub-module, lbsched_rmw: the sprite FSM plus target-bank latch. The top handles bank toggle, display mux and per-bank port steering.

Test Plan:
- Reset, then idle: pix_out=0, spr_ready=1, all we=0, draw_bank=0.
- Sprite write into empty draw bank 0: spr_x=0x010, spr_dat=0x123 → b0_we=1 at accept+2 with wadr=0x010, wdat=0x123. Then line_start, rd_en with hpos=0x010 → pix_out=0x123 next cycle, b0_clre=1. A second readout returns 0.
- Priority: write 0x105 then 0x2A7 to x=0x020 → second write suppressed, location stays 0x105. With LBSCHED_COLLISION_EN, coll=1 and coll_x=0x020.
- Transparent pixel: spr_dat=0x3F0 to x=0x030 → no we asserted, spr_ready low exactly 2 cycles.
- Swap mid-RMW: accept x=0x040 into bank 0, line_start in RD → b0_we in WR. Next pixel goes to bank 1, and display reads bank 0.
- Reset asserted in RD → no write occurs, spr_ready=1 one cycle after reset release.

Source files
------------

// File: rtl/lbsched_pkg.sv
// Shared types and helpers for the scanline-buffer ping-pong scheduler.
package lbsched_pkg;

  localparam int unsigned LB_AW = 10;
  localparam int unsigned LB_DW = 11;
  localparam int unsigned LB_TW = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } rmw_state_e;

  // A pixel is opaque when any colour-index bit (the tw LSBs) is set.
  function automatic logic is_opaque(input logic [31:0] dat, input int unsigned tw);
    logic [31:0] mask;
    mask = (32'd1 << tw) - 32'd1;
    return (dat & mask) != 32'd0;
  endfunction

endpackage

// File: rtl/lbsched_rmw.sv
// Sprite read-modify-write sequencer: IDLE -> RD -> WR, first opaque pixel wins.
// Optional collision reporting is built when LBSCHED_COLLISION_EN is defined.
module lbsched_rmw
  import lbsched_pkg::*;
#(
  parameter int unsigned AW = LB_AW,
  parameter int unsigned DW = LB_DW,
  parameter int unsigned TW = LB_TW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          draw_bank,
  input  logic          spr_valid,
  input  logic [AW-1:0] spr_x,
  input  logic [DW-1:0] spr_dat,
  output logic          spr_ready,
  output logic          busy,
  input  logic [DW-1:0] b0_rdat1,
  input  logic [DW-1:0] b1_rdat1,
  output logic          tgt_bank,
  output logic [AW-1:0] wadr,
  output logic [DW-1:0] wdat,
  output logic          we,
  output logic          coll,
  output logic [AW-1:0] coll_x
);

  rmw_state_e    state_q, state_d;
  logic [AW-1:0] x_q, x_d;
  logic [DW-1:0] dat_q, dat_d;
  logic          bank_q, bank_d;
  logic          ready_q, ready_d;
  logic          busy_q, busy_d;
  logic          we_c;
  logic          coll_c;
  logic [DW-1:0] old_dat;
  logic          old_opaque;
  logic          new_opaque;

  // Next-state, pixel latch and write decision.
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    dat_d      = dat_q;
    bank_d     = bank_q;
    we_c       = 1'b0;
    coll_c     = 1'b0;
    old_dat    = bank_q ? b1_rdat1 : b0_rdat1;
    old_opaque = is_opaque(32'(old_dat), TW);
    new_opaque = is_opaque(32'(dat_q), TW);
    case (state_q)
      IDLE: begin
        if (spr_valid) begin
          x_d     = spr_x;
          dat_d   = spr_dat;
          bank_d  = draw_bank;
          state_d = RD;
        end
      end
      RD:      state_d = WR;
      WR: begin
        we_c    = new_opaque && !old_opaque;
        coll_c  = new_opaque && old_opaque;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
  end

  // State and latched pixel registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      x_q     <= '0;
      dat_q   <= '0;
      bank_q  <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      dat_q   <= dat_d;
      bank_q  <= bank_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  assign spr_ready = ready_q;
  assign busy      = busy_q;
  assign tgt_bank  = bank_q;
  assign wadr      = x_q;
  assign wdat      = dat_q;
  // A reset arriving in WR drops the pending write.
  assign we        = we_c & ~reset;

`ifdef LBSCHED_COLLISION_EN
  logic          coll_q;
  logic [AW-1:0] coll_x_q, coll_x_d;

  // Collision x follows each pulse and holds until the next one.
  always_comb begin
    coll_x_d = coll_x_q;
    if (coll_c) coll_x_d = x_q;
  end

  // One-cycle collision pulse register.
  always_ff @(posedge clk) begin
    if (reset) begin
      coll_q   <= 1'b0;
      coll_x_q <= '0;
    end else begin
      coll_q   <= coll_c;
      coll_x_q <= coll_x_d;
    end
  end

  assign coll   = coll_q;
  assign coll_x = coll_x_q;
`else
  assign coll   = 1'b0;
  assign coll_x = '0;
`endif

endmodule

// File: rtl/linebuf_sched.sv
// Ping-pong scheduler for two scanline buffers: draw bank takes sprite RMW,
// display bank is scanned out and cleared; banks swap on line_start.
// Collision reporting is enabled with LBSCHED_COLLISION_EN.
module linebuf_sched
  import lbsched_pkg::*;
#(
  parameter int unsigned AW = LB_AW,
  parameter int unsigned DW = LB_DW,
  parameter int unsigned TW = LB_TW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          line_start,
  input  logic          rd_en,
  input  logic [AW-1:0] hpos,
  output logic [DW-1:0] pix_out,
  input  logic          spr_valid,
  output logic          spr_ready,
  input  logic [AW-1:0] spr_x,
  input  logic [DW-1:0] spr_dat,
  output logic          busy,
  output logic [AW-1:0] b0_radr,
  output logic [AW-1:0] b1_radr,
  output logic          b0_clre,
  output logic          b1_clre,
  input  logic [DW-1:0] b0_rdat,
  input  logic [DW-1:0] b1_rdat,
  output logic [AW-1:0] b0_wadr,
  output logic [AW-1:0] b1_wadr,
  output logic [DW-1:0] b0_wdat,
  output logic [DW-1:0] b1_wdat,
  output logic          b0_we,
  output logic          b1_we,
  input  logic [DW-1:0] b0_rdat1,
  input  logic [DW-1:0] b1_rdat1,
  output logic          coll,
  output logic [AW-1:0] coll_x
);

  logic          draw_bank_q, draw_bank_d;
  logic          rd_en_q, rd_en_d;
  logic          rd_sel_q, rd_sel_d;
  logic          tgt_bank;
  logic [AW-1:0] wadr;
  logic [DW-1:0] wdat;
  logic          we;

  lbsched_rmw #(.AW(AW), .DW(DW), .TW(TW)) u_rmw (
    .clk       (clk),
    .reset     (reset),
    .draw_bank (draw_bank_q),
    .spr_valid (spr_valid),
    .spr_x     (spr_x),
    .spr_dat   (spr_dat),
    .spr_ready (spr_ready),
    .busy      (busy),
    .b0_rdat1  (b0_rdat1),
    .b1_rdat1  (b1_rdat1),
    .tgt_bank  (tgt_bank),
    .wadr      (wadr),
    .wdat      (wdat),
    .we        (we),
    .coll      (coll),
    .coll_x    (coll_x)
  );

  // Bank toggle and display-read pipeline next values.
  always_comb begin
    draw_bank_d = draw_bank_q ^ line_start;
    rd_en_d     = rd_en;
    rd_sel_d    = ~draw_bank_q;
  end

  // Bank select and one-cycle read tracking registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      draw_bank_q <= 1'b0;
      rd_en_q     <= 1'b0;
      rd_sel_q    <= 1'b0;
    end else begin
      draw_bank_q <= draw_bank_d;
      rd_en_q     <= rd_en_d;
      rd_sel_q    <= rd_sel_d;
    end
  end

  // Per-bank port steering and display output mux.
  always_comb begin
    b0_radr = '0;
    b0_clre = 1'b0;
    b1_radr = '0;
    b1_clre = 1'b0;
    b0_wadr = '0;
    b0_wdat = '0;
    b0_we   = 1'b0;
    b1_wadr = '0;
    b1_wdat = '0;
    b1_we   = 1'b0;
    pix_out = '0;
    if (draw_bank_q) begin
      b0_radr = hpos;
      b0_clre = rd_en;
    end else begin
      b1_radr = hpos;
      b1_clre = rd_en;
    end
    if (tgt_bank) begin
      b1_wadr = wadr;
      b1_wdat = wdat;
      b1_we   = we;
    end else begin
      b0_wadr = wadr;
      b0_wdat = wdat;
      b0_we   = we;
    end
    if (rd_en_q) pix_out = rd_sel_q ? b1_rdat : b0_rdat;
  end

endmodule

// File: tb/tb_linebuf_sched.sv
// Scoreboard bench for linebuf_sched with a two-bank memory model.
module tb_linebuf_sched;
  import lbsched_pkg::*;

  localparam int unsigned AW = LB_AW;
  localparam int unsigned DW = LB_DW;
`ifdef LBSCHED_COLLISION_EN
  localparam bit COLL_EN = 1'b1;
`else
  localparam bit COLL_EN = 1'b0;
`endif

  typedef struct packed {
    logic          bank;
    logic [AW-1:0] adr;
    logic [DW-1:0] dat;
  } wr_t;

  logic          clk = 1'b0;
  logic          reset, line_start, rd_en, spr_valid;
  logic [AW-1:0] hpos, spr_x;
  logic [DW-1:0] spr_dat, pix_out;
  logic          spr_ready, busy;
  logic [AW-1:0] b0_radr, b1_radr, b0_wadr, b1_wadr, coll_x;
  logic          b0_clre, b1_clre, b0_we, b1_we, coll;
  logic [DW-1:0] b0_rdat, b1_rdat, b0_wdat, b1_wdat, b0_rdat1, b1_rdat1;

  logic [DW-1:0] mem0 [0:1023];
  logic [DW-1:0] mem1 [0:1023];
  bit            mem_init = 1'b0;

  int errs   = 0;
  int checks = 0;
  logic [DW-1:0] pq[$];
  wr_t           wq[$];

  linebuf_sched dut (
    .clk(clk), .reset(reset), .line_start(line_start), .rd_en(rd_en), .hpos(hpos),
    .pix_out(pix_out), .spr_valid(spr_valid), .spr_ready(spr_ready), .spr_x(spr_x),
    .spr_dat(spr_dat), .busy(busy), .b0_radr(b0_radr), .b1_radr(b1_radr),
    .b0_clre(b0_clre), .b1_clre(b1_clre), .b0_rdat(b0_rdat), .b1_rdat(b1_rdat),
    .b0_wadr(b0_wadr), .b1_wadr(b1_wadr), .b0_wdat(b0_wdat), .b1_wdat(b1_wdat),
    .b0_we(b0_we), .b1_we(b1_we), .b0_rdat1(b0_rdat1), .b1_rdat1(b1_rdat1),
    .coll(coll), .coll_x(coll_x)
  );

  always #5 clk = ~clk;

  // Buffer model: 1-cycle reads on both ports, clear then write (write wins).
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 1024; i++) begin
        mem0[i] = '0;
        mem1[i] = '0;
      end
      mem_init = 1'b1;
    end
    b0_rdat  <= mem0[b0_radr];
    b1_rdat  <= mem1[b1_radr];
    b0_rdat1 <= mem0[b0_wadr];
    b1_rdat1 <= mem1[b1_wadr];
    if (b0_clre) mem0[b0_radr] = '0;
    if (b1_clre) mem1[b1_radr] = '0;
    if (b0_we) mem0[b0_wadr] = b0_wdat;
    if (b1_we) mem1[b1_wadr] = b1_wdat;
  end

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_wr(input logic bank, input logic [AW-1:0] adr, input logic [DW-1:0] dat);
    wr_t e;
    wr_t a;
    a = {bank, adr, dat};
    if (wq.size() == 0) begin
      chk(1'b0, "wr_unexpected", 32'(a), 32'd0);
    end else begin
      e = wq.pop_front();
      chk(a == e, "wr", 32'(a), 32'(e));
    end
  endtask

  // Monitor: compares display pixels and bank writes as the DUT presents them.
  initial begin
    bit rd_prev;
    logic [DW-1:0] ex;
    rd_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rd_prev) begin
        if (pq.size() == 0) chk(1'b0, "pix_unexpected", 32'(pix_out), 32'd0);
        else begin
          ex = pq.pop_front();
          chk(pix_out == ex, "pix", 32'(pix_out), 32'(ex));
        end
      end else begin
        chk(pix_out == '0, "pix_idle", 32'(pix_out), 32'd0);
      end
      if (b0_we) chk_wr(1'b0, b0_wadr, b0_wdat);
      if (b1_we) chk_wr(1'b1, b1_wadr, b1_wdat);
      rd_prev = rd_en && !reset;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_line;
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
  endtask

  // One display read; expected pixel goes to the scoreboard.
  task automatic rd_pix(input logic [AW-1:0] a, input logic [DW-1:0] exp, input logic disp_bank);
    rd_en = 1'b1;
    hpos  = a;
    pq.push_back(exp);
    #1;
    chk((disp_bank ? b1_clre : b0_clre) == 1'b1, "clre_disp", 32'(disp_bank), 32'd1);
    chk((disp_bank ? b0_clre : b1_clre) == 1'b0, "clre_draw", 32'(disp_bank), 32'd0);
    chk((disp_bank ? b1_radr : b0_radr) == a, "radr", 32'(disp_bank ? b1_radr : b0_radr), 32'(a));
    tick();
    rd_en = 1'b0;
  endtask

  // mode 0: plain, 1: line_start during RD, 2: reset during RD.
  task automatic send_pix(input logic [AW-1:0] x, input logic [DW-1:0] d, input bit exp_we,
                          input logic exp_bank, input bit exp_coll, input int mode);
    int n;
    n = 0;
    while (!spr_ready && n < 20) begin
      tick();
      n++;
    end
    chk(spr_ready == 1'b1, "ready_wait", 32'(spr_ready), 32'd1);
    spr_valid = 1'b1;
    spr_x     = x;
    spr_dat   = d;
    if (exp_we) wq.push_back({exp_bank, x, d});
    tick();
    spr_valid = 1'b0;
    chk(spr_ready == 1'b0, "ready_rd", 32'(spr_ready), 32'd0);
    chk(busy == 1'b1, "busy_rd", 32'(busy), 32'd1);
    chk((b0_we | b1_we) == 1'b0, "we_rd", 32'({b1_we, b0_we}), 32'd0);
    if (mode == 1) line_start = 1'b1;
    if (mode == 2) reset = 1'b1;
    tick();
    line_start = 1'b0;
    if (mode == 2) begin
      chk(spr_ready == 1'b1, "ready_in_rst", 32'(spr_ready), 32'd1);
      chk((b0_we | b1_we) == 1'b0, "we_rst", 32'({b1_we, b0_we}), 32'd0);
      reset = 1'b0;
      tick();
      chk(spr_ready == 1'b1, "ready_post_rst", 32'(spr_ready), 32'd1);
      chk(busy == 1'b0, "busy_post_rst", 32'(busy), 32'd0);
      chk((b0_we | b1_we) == 1'b0, "we_post_rst", 32'({b1_we, b0_we}), 32'd0);
    end else begin
      chk(spr_ready == 1'b0, "ready_wr", 32'(spr_ready), 32'd0);
      chk((exp_bank ? b1_we : b0_we) == exp_we, "we_wr", 32'({b1_we, b0_we}), 32'(exp_we));
      chk((exp_bank ? b0_we : b1_we) == 1'b0, "we_other", 32'({b1_we, b0_we}), 32'd0);
      tick();
      chk(spr_ready == 1'b1, "ready_idle", 32'(spr_ready), 32'd1);
      chk(coll == (COLL_EN & exp_coll), "coll", 32'(coll), 32'(COLL_EN & exp_coll));
      if (COLL_EN && exp_coll) chk(coll_x == x, "coll_x", 32'(coll_x), 32'(x));
    end
  endtask

  // Directed stimulus.
  initial begin
    reset = 1'b1; line_start = 1'b0; rd_en = 1'b0; hpos = '0;
    spr_valid = 1'b0; spr_x = '0; spr_dat = '0;
    repeat (3) tick();
    chk(spr_ready == 1'b1, "rst_ready", 32'(spr_ready), 32'd1);
    chk(busy == 1'b0, "rst_busy", 32'(busy), 32'd0);
    chk({b1_we, b0_we, b1_clre, b0_clre} == 4'b0, "rst_strobes", 32'({b1_we, b0_we, b1_clre, b0_clre}), 32'd0);
    chk({b0_wadr, b1_wadr} == '0, "rst_wadr", 32'({b0_wadr, b1_wadr}), 32'd0);
    chk({b0_wdat, b1_wdat} == '0, "rst_wdat", 32'({b0_wdat, b1_wdat}), 32'd0);
    chk({coll, coll_x} == '0, "rst_coll", 32'({coll, coll_x}), 32'd0);
    reset = 1'b0;
    tick();
    // draw_bank=0 out of reset, so display is bank 1
    rd_pix(10'h005, 11'h000, 1'b1);

    // Write into empty bank 0, swap, read back and observe clear
    send_pix(10'h010, 11'h123, 1'b1, 1'b0, 1'b0, 0);
    send_pix(10'h3FF, 11'h00F, 1'b1, 1'b0, 1'b0, 0);
    pulse_line();
    rd_pix(10'h010, 11'h123, 1'b0);
    rd_pix(10'h010, 11'h000, 1'b0);
    rd_pix(10'h3FF, 11'h00F, 1'b0);

    // Priority: first opaque pixel wins in bank 1
    send_pix(10'h020, 11'h105, 1'b1, 1'b1, 1'b0, 0);
    send_pix(10'h020, 11'h2A7, 1'b0, 1'b1, 1'b1, 0);
    pulse_line();
    rd_pix(10'h020, 11'h105, 1'b1);

    // Transparent pixel into bank 0: no write
    send_pix(10'h030, 11'h3F0, 1'b0, 1'b0, 1'b0, 0);

    // Swap during RD: write lands in bank 0, next pixel in bank 1
    send_pix(10'h040, 11'h0A5, 1'b1, 1'b0, 1'b0, 1);
    send_pix(10'h041, 11'h007, 1'b1, 1'b1, 1'b0, 0);
    rd_pix(10'h040, 11'h0A5, 1'b0);
    rd_pix(10'h030, 11'h000, 1'b0);

    // Reset during RD: write dropped, draw bank back to 0
    send_pix(10'h050, 11'h111, 1'b0, 1'b1, 1'b0, 2);
    rd_pix(10'h050, 11'h000, 1'b1);
    rd_pix(10'h041, 11'h007, 1'b1);

    repeat (3) tick();
    chk(wq.size() == 0, "wq_drain", 32'(wq.size()), 32'd0);
    chk(pq.size() == 0, "pq_drain", 32'(pq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  // Bound on total run time.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
